alarm_event_queue: RTL
======================

ALARM_EVENT_QUEUE -- requirements
Module: alarm_event_queue

Interface
REQ-001 Parameter NUM_ALARMS, default 24, the number of alarm lines consumed; it equals the width of the alarm status bus that feeds this block.
REQ-002 Parameter DEPTH, default 8, the event FIFO depth in entries; it SHALL be a power of two.
REQ-003 Parameter STAMP_W, default 16, the timestamp width in bits.
REQ-004 Port clk, input, 1, the single block clock; every flop is on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset; when low, all state SHALL clear immediately.
REQ-006 Port alarm_data, input, NUM_ALARMS, the alarm finished bits; bit i high means alarm i fired, and a pulse lasts at least 1 cycle.
REQ-007 Port mask, input, NUM_ALARMS, per-alarm ignore bits; 1 means new rising edges on that line are discarded.
REQ-008 Port evt_valid, output, 1, high when a head event is available.
REQ-009 Port evt_id, output, 5, alarm index of the head event.
REQ-010 Port evt_stamp, output, STAMP_W, timestamp of the head event.
REQ-011 Port evt_ready, input, 1, consumer accept.
REQ-012 Port pending, output, NUM_ALARMS, detected edges not yet queued.
REQ-013 Port count, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-014 Port overflow, output, 1, sticky lost-event flag.
REQ-015 Port clr_overflow, input, 1, synchronous clear of overflow.

Function
REQ-016 Edge detect: prev <= alarm_data every cycle; rise = alarm_data & ~prev & ~mask, computed bitwise.
REQ-017 Pending update each cycle: pending <= (pending & ~grant) | rise, where grant is the one-hot bit being queued in that cycle.
REQ-018 Grant: when pending != 0 and a push is allowed, the lowest set index of pending (registered value) SHALL be granted; at most one grant per cycle.
REQ-019 Push allowed: count < DEPTH, or count == DEPTH with a pop in the same cycle.
REQ-020 A granted bit SHALL push the entry {id = index, stamp = stamp counter value in the grant cycle}.
REQ-021 When the FIFO is full with no pop, nothing is granted and pending holds; this backpressure SHALL NOT set overflow.
REQ-022 Coalescing: a rise on a bit that is already pending and not granted in that cycle SHALL set overflow and produce no second event.
REQ-023 A rise on a bit granted in the same cycle SHALL re-set that pending bit; this is not an overflow.
REQ-024 Stamp counter: free-running, +1 per cycle from 0 after reset, wraps from 2^STAMP_W-1 to 0 silently.
REQ-025 FIFO is first-word-fall-through: evt_valid = (count != 0); evt_id and evt_stamp show the head entry combinationally from storage.
REQ-026 Pop occurs when evt_valid && evt_ready; evt_ready with count == 0 has no effect.
REQ-027 A simultaneous push and pop leaves count unchanged; read and write pointers wrap modulo DEPTH.
REQ-028 Latency: with the FIFO empty, a rise sampled at edge E0 gives pending high after E0, and evt_valid high after E1 (2 cycles).
REQ-029 Event ordering: FIFO order is grant order; when several edges arrive in the same cycle, they are queued in ascending index, one per cycle.
REQ-030 Mask: setting a mask bit does not clear an existing pending bit, and that bit is still delivered.
REQ-031 overflow is set by REQ-022 and cleared by clr_overflow; if a set and a clear occur in the same cycle, set wins.

Reset
REQ-032 While reset is low: pending = 0, count = 0, evt_valid = 0, evt_id = 0, evt_stamp = 0, overflow = 0, stamp counter = 0, pointers = 0.
REQ-033 prev SHALL reset to all-ones, so alarm lines that are already high at reset release produce no event; only true 0->1 transitions after release count.
REQ-034 Reset asserted mid-operation discards all queued and pending events; there is no event replay after release.

Verification
REQ-035 Single event: after reset release, pulse alarm_data[5] for 2 cycles with evt_ready=1 -> evt_valid rises 2 cycles after the pulse for exactly 1 cycle, with evt_id=5 and evt_stamp = stamp value at the grant cycle.
REQ-036 Simultaneous edges: alarm_data bits 23, 7 and 0 rise in one cycle with evt_ready=0 -> count reaches 3 over 3 cycles; pops then return ids 0, 7, 23 in that order.
REQ-037 Backpressure: evt_ready=0 and 10 distinct alarms rise -> count=8, pending holds 2 bits, overflow=0; pop 2 -> the remaining 2 ids enter the FIFO and pending returns to 0.
REQ-038 Coalesce: evt_ready=0 with FIFO full and pending[3]=1, then alarm 3 rises again -> overflow=1 and only one id-3 event is queued; clr_overflow while alarm 4 coalesces in the same cycle -> overflow remains 1.
REQ-039 Mask and wrap: mask[2]=1 while alarm 2 pulses -> no event; run the stamp counter past 0xFFFF -> an event at that point carries stamp 0x0000 or 0x0001 matching the grant cycle.
REQ-040 Reset: hold alarm_data[9] high across a reset pulse while count=4 -> after release, count=0, no id-9 event, and overflow=0.

Source files
------------

// File: rtl/alarm_event_queue.sv
// alarm_event_queue: turns rising edges on a bank of alarm lines into a
// time-stamped event stream. Detected edges wait in a pending vector and are
// moved, lowest index first and one per cycle, into a first-word-fall-through
// FIFO. A second edge on a line that is still pending is lost and flagged.
module alarm_event_queue #(
  parameter int NUM_ALARMS = 24,
  parameter int DEPTH      = 8,
  parameter int STAMP_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_ALARMS-1:0]    alarm_data,
  input  logic [NUM_ALARMS-1:0]    mask,
  output logic                     evt_valid,
  output logic [4:0]               evt_id,
  output logic [STAMP_W-1:0]       evt_stamp,
  input  logic                     evt_ready,
  output logic [NUM_ALARMS-1:0]    pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: the head event is offered whenever evt_valid is high and its
  // id/stamp hold steady until accepted; it is consumed on a rising clk edge
  // where evt_valid && evt_ready. evt_ready alone (FIFO empty) does nothing.

  logic [NUM_ALARMS-1:0] prev;
  logic [NUM_ALARMS-1:0] rise;
  logic [NUM_ALARMS-1:0] grant;
  logic [4:0]            grant_idx;
  logic                  grant_any;
  logic                  pop;
  logic                  push_ok;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [STAMP_W-1:0]    stamp_cnt;
  logic [4:0]            id_mem    [DEPTH];
  logic [STAMP_W-1:0]    stamp_mem [DEPTH];

  assign rise      = alarm_data & ~prev & ~mask;
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign push_ok   = (count < CW'(DEPTH)) || pop;
  assign evt_id    = evt_valid ? id_mem[rd_ptr]    : '0;
  assign evt_stamp = evt_valid ? stamp_mem[rd_ptr] : '0;

  // Lowest-index pending bit wins the single grant slot of this cycle.
  always_comb begin
    grant_idx = '0;
    grant     = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending[i]) grant_idx = 5'(i);
    end
    grant_any = push_ok && (pending != '0);
    if (grant_any) grant = NUM_ALARMS'(1) << grant_idx;
  end

  // Edge history, pending vector, stamp counter and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev      <= '1;
      pending   <= '0;
      stamp_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      prev      <= alarm_data;
      pending   <= (pending & ~grant) | rise;
      stamp_cnt <= stamp_cnt + STAMP_W'(1);
      if ((rise & pending & ~grant) != '0) overflow <= 1'b1;
      else if (clr_overflow)               overflow <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_any) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({grant_any, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until covered by count.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      id_mem[wr_ptr]    <= grant_idx;
      stamp_mem[wr_ptr] <= stamp_cnt;
    end
  end

endmodule
